// File: rtl/mul_div_unit_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    localparam int WIDTH = 16;
    localparam int ITER  = 16;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MULS = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIVS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Radix-2 multiply/divide: result and done pulse 18 cycles after an accepted start.
// New requests are taken only when busy is low (IDLE or DONE); starts while busy are dropped.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = mul_div_unit_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   ma_q;
    logic [WIDTH-1:0]   mb_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH:0]     rem_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               dbz_q;

    logic               accept;
    logic               is_signed_in;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH+1:0]   div_diff;
    logic               div_fits;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;

    assign accept       = start && (state_q == IDLE || state_q == DONE);
    assign is_signed_in = op[0];
    assign abs_a        = (is_signed_in && a[WIDTH-1]) ? -a : a;
    assign abs_b        = (is_signed_in && b[WIDTH-1]) ? -b : b;

    // Multiply step: add multiplicand into the high half when the low bit is set, then shift right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, ma_q & {WIDTH{acc_q[0]}}};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: dividend bits shift out of acc_q[WIDTH-1:0], quotient bits shift in.
    assign div_diff = {rem_q, acc_q[WIDTH-1]} - {2'b00, mb_q};
    assign div_fits = ~div_diff[WIDTH+1];
    assign rem_next = div_fits ? div_diff[WIDTH:0] : {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    assign quo_next = {acc_q[WIDTH-2:0], div_fits};

    assign prod_fixed = neg_lo_q ? -acc_q : acc_q;
    assign quo_fixed  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fixed  = neg_hi_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN) || (state_q == FIX);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            a_q      <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else if (accept) begin
            op_q     <= op;
            a_q      <= a;
            ma_q     <= abs_a;
            mb_q     <= abs_b;
            // lo sign: product/quotient; hi sign: remainder follows the dividend.
            neg_lo_q <= is_signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_q <= is_signed_in && a[WIDTH-1];
            acc_q    <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            rem_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + CW'(1);
            if (op_q[1]) begin
                acc_q <= {{WIDTH{1'b0}}, quo_next};
                rem_q <= rem_next;
            end else begin
                acc_q <= mul_next;
            end
        end else if (state_q == FIX) begin
            if (op_q[1] && mb_q == '0) begin
                hi_q  <= a_q;
                lo_q  <= '1;
                dbz_q <= 1'b1;
            end else if (op_q[1]) begin
                hi_q  <= rem_fixed;
                lo_q  <= quo_fixed;
                dbz_q <= 1'b0;
            end else begin
                {hi_q, lo_q} <= prod_fixed;
                dbz_q        <= 1'b0;
            end
        end
    end

    assign hi  = hi_q;
    assign lo  = lo_q;
    assign dbz = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus directed literal cases.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        busy, done, dbz;
    logic [15:0] hi, lo;

    int errors = 0;
    int checks = 0;

    mul_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Returns {dbz, hi, lo} from plain integer arithmetic.
    function automatic logic [32:0] model(input logic [1:0] mop, input logic [15:0] ma, input logic [15:0] mb);
        longint p;
        int     sa, sb, q, r;
        logic [31:0] p32;
        logic [15:0] q16, r16;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        case (mop)
            2'b00: begin p = longint'(ma) * longint'(mb); p32 = p[31:0]; return {1'b0, p32}; end
            2'b01: begin p = longint'(sa) * longint'(sb); p32 = p[31:0]; return {1'b0, p32}; end
            2'b10: begin
                if (mb == 16'h0) return {1'b1, ma, 16'hFFFF};
                q = int'(ma) / int'(mb);
                r = int'(ma) % int'(mb);
            end
            default: begin
                if (mb == 16'h0) return {1'b1, ma, 16'hFFFF};
                q = sa / sb;
                r = sa % sb;
            end
        endcase
        q16 = q[15:0];
        r16 = r[15:0];
        return {1'b0, r16, q16};
    endfunction

    // Cycle-level expectation: an accepted op is busy for 17 cycles, then done for one.
    longint      e = 0;
    longint      k = 0;
    bit          pend = 0;
    logic [32:0] pend_res;
    logic        exp_busy = 0, exp_done = 0, exp_dbz = 0;
    logic [15:0] exp_hi = 0, exp_lo = 0;

    always @(posedge clk) begin
        e++;
        if (reset) begin
            pend = 0;
            exp_busy = 0; exp_done = 0;
            exp_hi = 0; exp_lo = 0; exp_dbz = 0;
        end else begin
            if (pend && e == k + 17) {exp_dbz, exp_hi, exp_lo} = pend_res;
            if (start && !(pend && (e - 1) <= k + 16)) begin
                pend     = 1;
                k        = e;
                pend_res = model(op, a, b);
            end
            exp_busy = pend && e >= k && e <= k + 16;
            exp_done = pend && e == k + 17;
        end
    end

    always @(negedge clk) begin
        if (e > 0) begin
            chk("cyc_busy", 32'(busy), 32'(exp_busy));
            chk("cyc_done", 32'(done), 32'(exp_done));
            chk("cyc_hi",   32'(hi),   32'(exp_hi));
            chk("cyc_lo",   32'(lo),   32'(exp_lo));
            chk("cyc_dbz",  32'(dbz),  32'(exp_dbz));
        end
    end

    // Called just after a negedge; returns after the following negedge with start dropped.
    task automatic pulse(input logic [1:0] pop, input logic [15:0] pa, input logic [15:0] pb);
        #1;
        start = 1'b1; op = pop; a = pa; b = pb;
        @(negedge clk);
        #1;
        start = 1'b0; op = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
    endtask

    task automatic wait_done(input string name, input int n0,
                             input logic [15:0] eh, input logic [15:0] el, input logic ed);
        int n;
        bit got;
        got = 0;
        for (n = n0; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL %s_timeout: no done within 40 cycles", name);
        end else begin
            chk({name, "_lat"}, 32'(n), 32'd18);
            chk({name, "_hi"}, 32'(hi), 32'(eh));
            chk({name, "_lo"}, 32'(lo), 32'(el));
            chk({name, "_dbz"}, 32'(dbz), 32'(ed));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hilo", {hi, lo}, 32'd0);
        chk("rst_dbz",  32'(dbz), 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);

        pulse(2'b00, 16'hFFFF, 16'hFFFF);
        wait_done("mulu_max", 2, 16'hFFFE, 16'h0001, 1'b0);
        pulse(2'b01, 16'hFFFD, 16'h0007);
        wait_done("muls_neg", 2, 16'hFFFF, 16'hFFEB, 1'b0);
        pulse(2'b01, 16'h8000, 16'h8000);
        wait_done("muls_min", 2, 16'h4000, 16'h0000, 1'b0);
        pulse(2'b10, 16'd100, 16'd7);
        wait_done("divu", 2, 16'd2, 16'd14, 1'b0);
        pulse(2'b11, 16'hFFF9, 16'h0002);
        wait_done("divs_neg", 2, 16'hFFFF, 16'hFFFD, 1'b0);
        pulse(2'b11, 16'h8000, 16'hFFFF);
        wait_done("divs_wrap", 2, 16'h0000, 16'h8000, 1'b0);
        pulse(2'b10, 16'h04D2, 16'h0000);
        wait_done("div_zero", 2, 16'h04D2, 16'hFFFF, 1'b1);
        pulse(2'b00, 16'd3, 16'd4);
        wait_done("mul_clr_dbz", 2, 16'h0000, 16'd12, 1'b0);
        pulse(2'b11, 16'hFF00, 16'h0000);
        wait_done("divs_zero", 2, 16'hFF00, 16'hFFFF, 1'b1);

        // A second start mid-RUN must not disturb the operation in flight.
        pulse(2'b10, 16'd1000, 16'd33);
        repeat (4) @(negedge clk);
        pulse(2'b00, 16'h1234, 16'h5678);
        wait_done("start_ignored", 7, 16'd10, 16'd30, 1'b0);

        // Abort at RUN iteration 8; no done may follow.
        @(negedge clk);
        pulse(2'b00, 16'h00FF, 16'h0101);
        repeat (8) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hilo", {hi, lo}, 32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: done=%b after aborted op", done);
            end
            checks++;
        end

        for (int i = 0; i < 2000; i++) begin
            #1;
            reset = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom);
            case ($urandom_range(0, 7))
                0:       a = 16'h8000;
                1:       a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       b = 16'h0000;
                1:       b = 16'hFFFF;
                2:       b = 16'h0001;
                default: b = 16'($urandom);
            endcase
            @(negedge clk);
        end
        #1 reset = 1'b0; start = 1'b0;
        repeat (25) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle integer multiply/divide unit for the 16-bit RISC processor.
- Sits directly downstream of the register file and consumes the A/B read buses driven by the 16-bit registers.
- Produces a 32-bit result {hi, lo} for the write-back path.
- Radix-2 iterative datapath; one iteration per clock.

Parameters:
- WIDTH, 16, operand width; result is 2*WIDTH. Only 16 is verified.

Ports:
- clk    input   1   system clock; all state changes on rising edge
- reset  input   1   synchronous, active-high reset
- start  input   1   request; accepted only when busy=0
- op     input   2   00 MULU, 01 MULS, 10 DIVU, 11 DIVS
- a      input   16  operand A (multiplicand / dividend), from register-file DA bus
- b      input   16  operand B (multiplier / divisor), from register-file DB bus
- busy   output  1   operation in progress
- done   output  1   one-cycle pulse: hi/lo/dbz valid and updated
- hi     output  16  MUL: product[31:16]; DIV: remainder
- lo     output  16  MUL: product[15:0]; DIV: quotient
- dbz    output  1   divide by zero on the last completed operation

Behaviour:
- Interface: one clock (clk). Reset (reset) is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - busy, done, dbz, hi, lo, and the iteration counter are all 0.
- Reset mid-operation: aborts the operation immediately. No done pulse is issued, and outputs return to 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE or DONE, start=1 (accept edge k):
  - Latch op, a, b.
  - For signed ops, latch the magnitudes |a| and |b| plus the result-sign bits.
  - Clear the counter; next state = RUN.
- DONE with start=0: next state = IDLE.
- RUN: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle. After 16 steps (edges k+1..k+16), next state = FIX.
- FIX (edge k+17):
  - Apply sign correction.
  - Load hi, lo, dbz.
  - Next state = DONE.
- Timing:
  - done=1 in the cycle following edge k+17, i.e. 18 cycles after the start cycle, for exactly 1 cycle.
  - Latency is identical for all ops, including divide by zero.
- busy = 1 in RUN and FIX only; 0 in IDLE and DONE. Back-to-back start in the DONE cycle is accepted, giving 18-cycle throughput.
- start while busy=1: ignored, with no effect on the operation in flight.
- a, b, and op changes after acceptance are ignored.
- hi, lo, dbz hold their values until the next FIX (or reset).
- MULU: full unsigned 32-bit product.
- MULS: two's-complement 32-bit product; negate when sign(a) XOR sign(b).
- DIVU: unsigned quotient and remainder.
- DIVS:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x8000 / 0xFFFF yields lo=0x8000, hi=0x0000, dbz=0. The wrap is intentional and no flag is raised.
- Divide by zero (DIVU or DIVS, b=0):
  - lo = 0xFFFF, hi = the original a (unmodified), dbz = 1.
- dbz = 0 for all MUL ops and for any nonzero divisor.
- Internal widths:
  - 17-bit partial remainder for division.
  - 32-bit accumulator for multiplication, with a 5-bit iteration counter.

Decomposition:
- Shared package contents:
  - Op encodings: OP_MULU, OP_MULS, OP_DIVU, OP_DIVS.
  - State encodings: IDLE, RUN, FIX, DONE.
  - Constants: WIDTH=16, ITER=16.
- Single module; no sub-module required.
- The sign handling (abs-in / negate-out) can optionally be a small combinational helper, mdu_sign_fix, reused at input and output.

Test Plan:
- MULU a=0xFFFF b=0xFFFF -> done exactly 18 cycles after start; hi=0xFFFE lo=0x0001 dbz=0; busy high for 17 cycles.
- MULS a=0xFFFD(-3) b=0x0007 -> hi=0xFFFF lo=0xFFEB; MULS a=0x8000 b=0x8000 -> hi=0x4000 lo=0x0000.
- DIVU a=100 b=7 -> lo=14 hi=2; DIVS a=0xFFF9(-7) b=2 -> lo=0xFFFD hi=0xFFFF; DIVS a=0x8000 b=0xFFFF -> lo=0x8000 hi=0x0000.
- DIVU a=0x04D2 b=0 -> lo=0xFFFF hi=0x04D2 dbz=1 after 18 cycles; a following MULU 3*4 clears dbz and gives lo=12.
- Start pulsed mid-RUN with different a/b -> ignored, original result delivered; start in DONE cycle -> next op accepted, done again 18 cycles later.
- Reset asserted at RUN iteration 8 -> next cycle busy=0 done=0 hi=lo=0; no done pulse ever appears for the aborted op.
